motion_sequencer: RTL and testbench
===================================

# motion_sequencer

Command-queued motion controller for the TI-RSLK-MAX chassis on the WebFPGA Shasta board. It owns both motor channels (enable, direction, drive) and the two wheel encoders. It executes a short queue of motion commands (forward, back, spin right, spin left), each for a programmed number of encoder ticks. A forward move aborts on a bumper hit. It sits between the top-level behaviour FSM, which pushes commands, and the pwm instances, which receive the drive gates.

## Interface
- DEPTH, 4: command FIFO entries; power of 2, at least 2
- CNT_W, 12: width of tick target and tick counters
- SETTLE, 16'd8000: coast cycles with drive low between commands
- WF_CLK  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_op  in  2  00 fwd, 01 back, 10 spin right, 11 spin left
- cmd_ticks  in  CNT_W  encoder rising edges to travel
- motorL_encdr, motorR_encdr  in  1  raw encoder pins (asynchronous)
- bump_n  in  6  bumper switches, active-low
- clear_fault  in  1  single-cycle pulse that leaves FAULT
- motorL_en, motorL_dir, motorL_drive  out  1 each  left channel
- motorR_en, motorR_dir, motorR_drive  out  1 each  right channel
- busy  out  1  state not IDLE, or FIFO not empty
- done  out  1  one-cycle pulse when a command reaches its tick target
- fault  out  1  high while in FAULT
- bump_latched  out  6  bump_n inverted, captured on abort
- level  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- FIFO
  - A push happens when cmd_valid && cmd_ready; the entry is {op, ticks}.
  - cmd_ready = !full && state != FAULT.
  - A pop happens on IDLE→LOAD only.
  - Push and pop in the same cycle: level is unchanged.
  - Pointers wrap modulo DEPTH.
- Encoders
  - Each pin passes through a 2-flop synchronizer plus an edge flop.
  - A rising edge increments that wheel's counter only while in RUN.
  - Counters saturate at 2^CNT_W-1.
- States
  - IDLE: en=0, drive=0. Go to LOAD if the FIFO is not empty.
  - LOAD: en=1, drive=0. Dirs come from the popped op. Clear both counters and the SETTLE counter. Go to RUN.
  - RUN: en=1, drive=1. When cntL >= ticks or cntR >= ticks, pulse done and go to SETTLE. ticks=0 completes on the first RUN cycle.
  - SETTLE: en=1, drive=0, dirs held. Count SETTLE cycles, then go to IDLE.
  - FAULT: en=0, drive=0. FIFO is flushed on entry. Go to IDLE on clear_fault.
- Direction per op (L/R dir)
  - fwd: 0/0
  - back: 1/1
  - spin right: 0/1
  - spin left: 1/0
- Bump abort
  - Any bump_n bit low while in RUN with op fwd triggers it.
  - Takes priority over tick completion in the same cycle: done is not pulsed.
  - Captures ~bump_n into bump_latched and enters FAULT.
  - Bumps are ignored during back and spin ops and in all other states.
- bump_latched holds its value until the next abort or reset.

## Timing
- Reset values:
  - All motor outputs 0.
  - done=0, fault=0, busy=0, bump_latched=0, level=0.
  - cmd_ready=1, state IDLE, FIFO empty, counters 0.
- Latency from push (into empty FIFO, IDLE) to drive=1 is 3 cycles: push edge, IDLE→LOAD, LOAD→RUN.
- Encoder pin edge to counter increment: 3 cycles.
- done asserts in the cycle the state becomes SETTLE and lasts exactly 1 cycle.
- Back-to-back commands: drive is low for 1 + SETTLE + 1 + 1 cycles between RUN periods (SETTLE, IDLE, LOAD).
- Reset asserted mid-operation: outputs drop to reset values asynchronously. Queued commands are lost.
- clear_fault outside FAULT has no effect.

## Configuration
- MOTION_SEQ_BUMP_EN defined:
  - Bump abort, the FAULT state, bump_latched capture and FIFO flush are compiled in.
- MOTION_SEQ_BUMP_EN undefined:
  - bump_n and clear_fault are unused.
  - fault and bump_latched are tied to 0.
  - FAULT is unreachable.
  - cmd_ready = !full.

## Test plan
- Reset, push fwd ticks=5 with SETTLE=4, toggle motorR_encdr 5 times -> drive high 3 cycles after push; both dirs 0; done pulses once after the 5th edge plus 3 cycles; idle after 4 coast cycles.
- Push 5 commands with DEPTH=4 while encoders are stalled -> cmd_ready drops after 4 accepted (level=4); 5th held until the first pop; ops execute in order with the dir patterns above.
- ticks=0 spin left -> L dir 1, R dir 0; done on the first RUN cycle; no encoder edges needed.
- fwd ticks=100, 3 queued commands, drive bump_n=6'b111011 mid-RUN -> fault=1, bump_latched=6'b000100, level=0, all motor outputs 0, no done; clear_fault pulse -> IDLE, cmd_ready=1.
- back ticks=10 with bump_n=0 the whole time -> no abort; done after 10 edges.
- Assert rst_n low during RUN -> all outputs return to reset values in the same cycle; FIFO empty after release.

Source files
------------

// File: rtl/motion_sequencer.sv
// motion_sequencer: queued encoder-tick motion commands driving both motor channels.
// Optional bump abort / FAULT state is compiled in with `define MOTION_SEQ_BUMP_EN.
module motion_sequencer #(
    parameter int          DEPTH  = 4,
    parameter int          CNT_W  = 12,
    parameter logic [15:0] SETTLE = 16'd8000
) (
    input  logic                     WF_CLK,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_ticks,
    input  logic                     motorL_encdr,
    input  logic                     motorR_encdr,
    input  logic [5:0]               bump_n,
    input  logic                     clear_fault,
    output logic                     motorL_en,
    output logic                     motorL_dir,
    output logic                     motorL_drive,
    output logic                     motorR_en,
    output logic                     motorR_dir,
    output logic                     motorR_drive,
    output logic                     busy,
    output logic                     done,
    output logic                     fault,
    output logic [5:0]               bump_latched,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] OP_FWD = 2'b00;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_SETTLE, S_FAULT} state_t;
    state_t state_q, state_d;

    logic [CNT_W+1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        level_q;
    logic [1:0]         cur_op_q;
    logic [CNT_W-1:0]   cur_ticks_q, cntL_q, cntR_q;
    logic [15:0]        settle_q;
    logic [1:0]         s1_q, s2_q, prev_q, rise;
    logic               done_q, complete, abort, hit, full, empty, push, pop, en, dir_l, dir_r;
    logic [5:0]         bump_q;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
`ifdef MOTION_SEQ_BUMP_EN
    assign cmd_ready = !full && (state_q != S_FAULT);
`else
    assign cmd_ready = !full;
    logic unused_cfg;
    assign unused_cfg = ^{bump_n, clear_fault};
`endif
    assign push = cmd_valid && cmd_ready;
    assign pop  = (state_q == S_IDLE) && !empty;
    assign rise = s2_q & ~prev_q;
    assign hit  = (cntL_q >= cur_ticks_q) || (cntR_q >= cur_ticks_q);

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            S_IDLE:   if (!empty) state_d = S_LOAD;
            S_LOAD:   state_d = S_RUN;
            S_RUN: begin
`ifdef MOTION_SEQ_BUMP_EN
                // A bump during a forward move wins over a same-cycle tick completion.
                if (cur_op_q == OP_FWD && bump_n != 6'h3f) begin
                    abort   = 1'b1;
                    state_d = S_FAULT;
                end else
`endif
                if (hit) begin
                    complete = 1'b1;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: if (settle_q == SETTLE) state_d = S_IDLE;
`ifdef MOTION_SEQ_BUMP_EN
            S_FAULT:  if (clear_fault) state_d = S_IDLE;
`else
            S_FAULT:  state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge WF_CLK) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_ticks};
    end

    always_ff @(posedge WF_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cur_op_q    <= '0;
            cur_ticks_q <= '0;
            cntL_q      <= '0;
            cntR_q      <= '0;
            settle_q    <= '0;
            done_q      <= 1'b0;
            bump_q      <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            prev_q      <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= complete;
            s1_q    <= {motorL_encdr, motorR_encdr};
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            if (abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
                bump_q   <= ~bump_n;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop) begin
                    rd_ptr_q    <= rd_ptr_q + AW'(1);
                    cur_op_q    <= mem_q[rd_ptr_q][CNT_W+1:CNT_W];
                    cur_ticks_q <= mem_q[rd_ptr_q][CNT_W-1:0];
                end
                if (push && !pop)      level_q <= level_q + (AW+1)'(1);
                else if (pop && !push) level_q <= level_q - (AW+1)'(1);
            end
            if (state_q == S_LOAD) begin
                cntL_q   <= '0;
                cntR_q   <= '0;
                settle_q <= '0;
            end else begin
                if (state_q == S_RUN && rise[1] && cntL_q != '1) cntL_q <= cntL_q + CNT_W'(1);
                if (state_q == S_RUN && rise[0] && cntR_q != '1) cntR_q <= cntR_q + CNT_W'(1);
                if (state_q == S_SETTLE) settle_q <= settle_q + 16'd1;
            end
        end
    end

    // Direction bits: L follows op[0]; R is set for back and spin right.
    assign en           = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_SETTLE);
    assign dir_l        = cur_op_q[0];
    assign dir_r        = cur_op_q[1] ^ cur_op_q[0];
    assign motorL_en    = en;
    assign motorR_en    = en;
    assign motorL_dir   = en && dir_l;
    assign motorR_dir   = en && dir_r;
    assign motorL_drive = (state_q == S_RUN);
    assign motorR_drive = (state_q == S_RUN);
    assign busy         = (state_q != S_IDLE) || !empty;
    assign done         = done_q;
    assign level        = level_q;
`ifdef MOTION_SEQ_BUMP_EN
    assign fault        = (state_q == S_FAULT);
    assign bump_latched = bump_q;
`else
    assign fault        = 1'b0;
    assign bump_latched = '0;
    logic unused_bump;
    assign unused_bump = ^bump_q;
`endif
endmodule

// File: tb/tb_motion_sequencer.sv
// Bench for motion_sequencer: random command streams checked against a command-level model.
module tb_motion_sequencer;
    localparam int          DEPTH  = 4;
    localparam int          CNT_W  = 12;
    localparam logic [15:0] SETTLE = 16'd4;

    logic             WF_CLK = 1'b0;
    logic             rst_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = '0;
    logic [CNT_W-1:0] cmd_ticks = '0;
    logic             motorL_encdr = 1'b0, motorR_encdr = 1'b0;
    logic [5:0]       bump_n = 6'h3f;
    logic             clear_fault = 1'b0;
    logic             cmd_ready, motorL_en, motorL_dir, motorL_drive;
    logic             motorR_en, motorR_dir, motorR_drive, busy, done, fault;
    logic [5:0]       bump_latched;
    logic [2:0]       level;

    motion_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
        .WF_CLK(WF_CLK), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ticks(cmd_ticks), .motorL_encdr(motorL_encdr),
        .motorR_encdr(motorR_encdr), .bump_n(bump_n), .clear_fault(clear_fault),
        .motorL_en(motorL_en), .motorL_dir(motorL_dir), .motorL_drive(motorL_drive),
        .motorR_en(motorR_en), .motorR_dir(motorR_dir), .motorR_drive(motorR_drive),
        .busy(busy), .done(done), .fault(fault), .bump_latched(bump_latched), .level(level)
    );

    always #5 WF_CLK = ~WF_CLK;

    typedef struct { logic [1:0] op; int ticks; } cmd_t;
    cmd_t exp_q[$];
    int   n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {L dir, R dir} for each op, straight from the direction table.
    function automatic logic [1:0] exp_dirs(input logic [1:0] op);
        case (op)
            2'b00:   return 2'b00;
            2'b01:   return 2'b11;
            2'b10:   return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    task automatic step();
        logic acc;
        cmd_t c;
        acc = cmd_valid && cmd_ready;
        @(posedge WF_CLK); #1;
        if (acc) begin
            c.op = cmd_op; c.ticks = int'(cmd_ticks);
            exp_q.push_back(c);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic offer(input logic [1:0] op, input int ticks);
        cmd_op = op; cmd_ticks = CNT_W'(ticks); cmd_valid = 1'b1;
    endtask

    task automatic push(input logic [1:0] op, input int ticks);
        int n;
        offer(op, ticks);
        n = 0;
        while (cmd_valid && n < 50) begin step(); n++; end
        check("push_accept", {31'd0, cmd_valid}, 0);
    endtask

    function automatic logic [6:0] motors();
        return {motorL_en, motorL_dir, motorL_drive, motorR_en, motorR_dir, motorR_drive, done};
    endfunction

    // Executes the oldest expected command; lead < 0 skips the start-latency check.
    task automatic run_one(input int lead);
        cmd_t c;
        int   waited, cl, cr;
        if (exp_q.size() == 0) return;
        c = exp_q.pop_front();
        waited = 0;
        while (motorL_drive !== 1'b1 && waited < 40) begin step(); waited++; end
        if (lead >= 0) check("lead_to_drive", waited, lead);
        check("run_start", {motorL_en, motorL_drive, motorR_en, motorR_drive}, 4'hf);
        if (motorL_drive !== 1'b1) return;
        check("run_dirs", {motorL_dir, motorR_dir}, exp_dirs(c.op));
        cl = 0; cr = 0;
        while (cl < c.ticks && cr < c.ticks) begin
            if ($urandom_range(0, 1) == 1) begin motorL_encdr = 1'b1; cl++; end
            else begin motorR_encdr = 1'b1; cr++; end
            if (cl < c.ticks && cr < c.ticks) begin
                repeat (2) begin step(); check("run_hold", {motorL_drive, done}, 2'b10); end
                motorL_encdr = 1'b0; motorR_encdr = 1'b0;
                repeat (2) begin step(); check("run_hold", {motorL_drive, done}, 2'b10); end
            end
        end
        if (c.ticks > 0) repeat (3) begin
            step(); check("pre_done", {motorL_drive, done}, 2'b10);
        end
        step();
        check("done_pulse", {done, motorL_en, motorL_drive, motorR_en, motorR_drive}, 5'b11010);
        check("settle_dirs", {motorL_dir, motorR_dir}, exp_dirs(c.op));
        motorL_encdr = 1'b0; motorR_encdr = 1'b0;
        for (int k = 0; k < int'(SETTLE); k++) begin
            step(); check("settle", {done, motorL_en, motorL_drive}, 3'b010);
        end
        step();
        check("idle_after", motors(), 7'd0);
        if (exp_q.size() == 0 && !cmd_valid) check("idle_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        logic [1:0] rop;
        logic [5:0] bpat;
        int         n;
        #1 rst_n = 1'b0;
        step(); step();
        check("rst_motors", motors(), 7'd0);
        check("rst_flags", {busy, fault, bump_latched, level, cmd_ready}, 12'h001);
        #3 rst_n = 1'b1;
        step();

        // Single forward move, then a zero-tick spin left.
        push(2'b00, 5);
        check("lvl_after_push", level, 1);
        run_one(2);
        push(2'b11, 0);
        run_one(2);

        // Fill the FIFO while the head command is stalled; first push pairs with the pop.
        offer(2'b00, $urandom_range(1, 4)); step(); check("lvl_p1", level, 1);
        offer(2'b01, $urandom_range(0, 4)); step(); check("lvl_pushpop", level, 1);
        offer(2'b10, $urandom_range(0, 4)); step(); check("lvl_p3", level, 2);
        offer(2'b11, $urandom_range(0, 4)); step(); check("lvl_p4", level, 3);
        offer(2'($urandom_range(1, 3)), $urandom_range(0, 4)); step(); check("lvl_p5", level, 4);
        check("ready_full", {31'd0, cmd_ready}, 0);
        offer(2'($urandom_range(1, 3)), $urandom_range(0, 4)); step();
        check("held_full", {31'd0, cmd_valid}, 1);
        check("lvl_full", level, 4);
        run_one(-1);
        while (exp_q.size() > 0) run_one(2);

        // Random back-to-back bursts.
        repeat (3) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) push(2'($urandom_range(1, 3)), $urandom_range(0, 6));
            run_one(-1);
            while (exp_q.size() > 0) run_one(2);
        end

        // Reverse with every bumper pressed must not abort.
        bump_n = 6'h00;
        push(2'b01, 10);
        run_one(2);
        check("back_no_fault", {31'd0, fault}, 0);
        bump_n = 6'h3f;

`ifdef MOTION_SEQ_BUMP_EN
        push(2'b00, 100);
        for (int i = 0; i < 3; i++) push(2'($urandom_range(0, 3)), $urandom_range(0, 6));
        n = 0;
        while (motorL_drive !== 1'b1 && n < 40) begin step(); n++; end
        check("bump_run", {31'd0, motorL_drive}, 1);
        check("lvl_before_bump", level, 3);
        step(); step();
        bpat = 6'b111011;
        bump_n = bpat;
        step();
        bump_n = 6'h3f;
        exp_q.delete();
        check("abort_fault", {31'd0, fault}, 1);
        check("abort_latch", bump_latched, ~bpat);
        check("abort_flush", level, 0);
        check("abort_motors", motors(), 7'd0);
        check("abort_ready", {31'd0, cmd_ready}, 0);
        repeat (3) begin step(); check("fault_hold", {fault, done}, 2'b10); end
        clear_fault = 1'b1; step(); clear_fault = 1'b0;
        check("clear_fault", {fault, cmd_ready, busy}, 3'b010);
        check("latch_hold", bump_latched, ~bpat);
`else
        bump_n = 6'b111011;
        push(2'b00, 6);
        run_one(2);
        check("nobump_flags", {fault, bump_latched}, 7'd0);
        bump_n = 6'h3f;
`endif
        clear_fault = 1'b1; step(); clear_fault = 1'b0;
        check("clear_idle", {motors(), fault, busy, cmd_ready}, 10'd1);

        // Reset in the middle of a move.
        push(2'b00, 50);
        push(2'b10, 3);
        n = 0;
        while (motorL_drive !== 1'b1 && n < 40) begin step(); n++; end
        check("pre_rst_run", {31'd0, motorL_drive}, 1);
        step();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("rst_mid_motors", motors(), 7'd0);
        check("rst_mid_flags", {busy, fault, bump_latched, level, cmd_ready}, 12'h001);
        #20 rst_n = 1'b1;
        step(); step();
        check("post_rst", {motors(), busy, level, cmd_ready}, 12'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
